// File: rtl/weight_ram_ctrl_pkg.sv
// rtl/weight_ram_ctrl_pkg.sv - shared types and constants for the weight RAM controller
package weight_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Replay FIFO depth and read pipeline length (address register + RAM latency)
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT     = 2;

    // Ceiling log2; log2(1) is 0
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/row_skid_fifo.sv
// rtl/row_skid_fifo.sv - small synchronous FIFO buffering replayed rows
module row_skid_fifo
    import weight_ram_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = log2(DEPTH),
    parameter int CNT_W = log2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;

    // Next-state for storage, pointers (power-of-two wrap) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; reset empties the FIFO and zeroes the storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/weight_ram_ctrl.sv
// rtl/weight_ram_ctrl.sv - weight RAM load sequencer and row replay arbiter
module weight_ram_ctrl
    import weight_ram_ctrl_pkg::*;
#(
    parameter int NROW             = 16,
    parameter int NCOL             = 16,
    parameter int BITWIDTH         = 18,
    parameter int OUTPUT_PORT_SIZE = BITWIDTH * NROW,
    parameter int ADDR_BITWIDTH    = log2(NCOL)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [OUTPUT_PORT_SIZE-1:0] load_data,
    output logic                        load_done,
    input  logic                        run_start,
    input  logic [7:0]                  run_passes,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [OUTPUT_PORT_SIZE-1:0] row_data,
    output logic                        row_last,
    output logic                        run_done,
    output logic                        busy,
    output logic [ADDR_BITWIDTH-1:0]    ram_addr,
    output logic                        ram_wren,
    output logic [OUTPUT_PORT_SIZE-1:0] ram_data,
    input  logic [OUTPUT_PORT_SIZE-1:0] ram_q
);

    localparam int                     CNT_W     = log2(FIFO_DEPTH + 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [CNT_W:0]         CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

    state_e                      state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITWIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]                  pass_cnt_q, pass_cnt_d;
    logic [ADDR_BITWIDTH-1:0]    ram_addr_q, ram_addr_d;
    logic                        ram_wren_q, ram_wren_d;
    logic [OUTPUT_PORT_SIZE-1:0] ram_data_q, ram_data_d;
    logic                        load_done_q, load_done_d;
    logic [RD_LAT-1:0]           vld_sh_q, vld_sh_d;
    logic [RD_LAT-1:0]           last_sh_q, last_sh_d;

    logic                        issue;
    logic                        issue_last;
    logic                        credit_ok;
    logic [CNT_W-1:0]            inflight;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    logic [OUTPUT_PORT_SIZE:0]   fifo_head;
    logic                        row_pop;
    logic                        run_done_c;

    row_skid_fifo #(
        .WIDTH (OUTPUT_PORT_SIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_sh_q[RD_LAT-1]),
        .push_data ({last_sh_q[RD_LAT-1], ram_q}),
        .pop       (row_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign row_valid  = !fifo_empty;
    assign row_data   = fifo_head[OUTPUT_PORT_SIZE-1:0];
    assign row_last   = row_valid && fifo_head[OUTPUT_PORT_SIZE];
    assign row_pop    = row_valid && row_ready;
    assign run_done   = run_done_c;
    assign load_ready = (state_q == LOAD);
    assign load_done  = load_done_q;
    assign busy       = (state_q != IDLE);
    assign ram_addr   = ram_addr_q;
    assign ram_wren   = ram_wren_q;
    assign ram_data   = ram_data_q;

    // Credit check: buffered rows plus reads in flight must leave a free FIFO slot
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sh_q[i]);
        end
        credit_ok = (({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS);
    end

    // Sequencer: next state, RAM port drive, pointers and read pipeline tags
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pass_cnt_d  = pass_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wren_d  = 1'b0;
        ram_data_d  = ram_data_q;
        load_done_d = 1'b0;
        issue       = 1'b0;
        issue_last  = 1'b0;
        run_done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end else if (run_start) begin
                    state_d    = READ;
                    rd_ptr_d   = '0;
                    pass_cnt_d = (run_passes == 8'd0) ? 8'd1 : run_passes;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    ram_wren_d = 1'b1;
                    ram_addr_d = wr_ptr_q;
                    ram_data_d = load_data;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    ram_addr_d = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_ADDR) begin
                        if (pass_cnt_q == 8'd1) begin
                            issue_last = 1'b1;
                            state_d    = DRAIN;
                        end else begin
                            pass_cnt_d = pass_cnt_q - 8'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (row_pop && row_last) begin
                    run_done_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        vld_sh_d  = {vld_sh_q[RD_LAT-2:0], issue};
        last_sh_d = {last_sh_q[RD_LAT-2:0], issue_last};
    end

    // State registers; reset aborts any load or replay in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_cnt_q  <= '0;
            ram_addr_q  <= '0;
            ram_wren_q  <= 1'b0;
            ram_data_q  <= '0;
            load_done_q <= 1'b0;
            vld_sh_q    <= '0;
            last_sh_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pass_cnt_q  <= pass_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wren_q  <= ram_wren_d;
            ram_data_q  <= ram_data_d;
            load_done_q <= load_done_d;
            vld_sh_q    <= vld_sh_d;
            last_sh_q   <= last_sh_d;
        end
    end

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// tb/tb_weight_ram_ctrl.sv - scoreboard testbench for weight_ram_ctrl
module tb_weight_ram_ctrl;

    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int OPS  = BW * NROW;
    localparam int AW   = 4;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [OPS-1:0] data;
        logic           last;
    } wr_t;

    typedef struct packed {
        logic [OPS-1:0] data;
        logic           last;
    } row_t;

    logic           clk;
    logic           rst_n;
    logic           load_start;
    logic           load_valid;
    logic           load_ready;
    logic [OPS-1:0] load_data;
    logic           load_done;
    logic           run_start;
    logic [7:0]     run_passes;
    logic           row_valid;
    logic           row_ready;
    logic [OPS-1:0] row_data;
    logic           row_last;
    logic           run_done;
    logic           busy;
    logic [AW-1:0]  ram_addr;
    logic           ram_wren;
    logic [OPS-1:0] ram_data;
    logic [OPS-1:0] ram_q;

    logic [OPS-1:0] ram_mem [NCOL];
    logic [OPS-1:0] exp_mem [NCOL];
    wr_t            wq [$];
    row_t           rq [$];

    int tests = 0;
    int fails = 0;
    int load_done_cnt = 0;
    int run_done_cnt = 0;
    int rows_seen = 0;

    weight_ram_ctrl #(
        .NROW     (NROW),
        .NCOL     (NCOL),
        .BITWIDTH (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_done  (load_done),
        .run_start  (run_start),
        .run_passes (run_passes),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_last   (row_last),
        .run_done   (run_done),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_data   (ram_data),
        .ram_q      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM model
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OPS-1:0] mk_word(input int k, input int salt);
        logic [OPS-1:0] w;
        for (int e = 0; e < NROW; e++) begin
            w[e*BW +: BW] = BW'((k << 11) + salt * e);
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows(input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < NCOL; k++) begin
                rq.push_back('{data: exp_mem[k], last: (p == passes - 1) && (k == NCOL - 1)});
            end
        end
    endtask

    task automatic push_writes(input int n, input int salt, input logic done_at_end);
        for (int k = 0; k < n; k++) begin
            wq.push_back('{addr: AW'(k), data: mk_word(k, salt), last: done_at_end && (k == n - 1)});
        end
    endtask

    task automatic wait_run_done(input int budget);
        int base;
        int cyc;
        base = run_done_cnt;
        cyc = 0;
        while (run_done_cnt == base && cyc < budget) begin
            step();
            cyc++;
        end
        check("run_done_seen", 320'(run_done_cnt - base), 320'd1);
    endtask

    // Monitor: RAM writes and accepted rows are popped from the scoreboard queues
    logic           stall_prev = 1'b0;
    logic [OPS-1:0] prev_data;
    logic           prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (ram_wren) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 320'd1, 320'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", 320'(ram_addr), 320'(w.addr));
                    check("wr_data", 320'(ram_data), 320'(w.data));
                    check("load_done_align", 320'(load_done), 320'(w.last));
                end
            end else if (load_done) begin
                check("load_done_without_write", 320'd1, 320'd0);
            end
            if (load_done) load_done_cnt++;
            if (stall_prev) begin
                check("stall_valid", 320'(row_valid), 320'd1);
                check("stall_data", 320'(row_data), 320'(prev_data));
                check("stall_last", 320'(row_last), 320'(prev_last));
            end
            if (row_valid && row_ready) begin
                rows_seen++;
                if (rq.size() == 0) begin
                    check("unexpected_row", 320'd1, 320'd0);
                end else begin
                    row_t r;
                    r = rq.pop_front();
                    check("row_data", 320'(row_data), 320'(r.data));
                    check("row_last", 320'(row_last), 320'(r.last));
                    check("run_done_align", 320'(run_done), 320'(r.last));
                end
            end else if (run_done) begin
                check("run_done_without_beat", 320'd1, 320'd0);
            end
            if (run_done) run_done_cnt++;
            stall_prev = row_valid && !row_ready;
            prev_data  = row_data;
            prev_last  = row_last;
        end
    end

    initial begin
        int base;
        int cyc;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        run_start = 1'b0;
        run_passes = 8'd0;
        row_ready = 1'b0;
        step();
        check("rst_busy", 320'(busy), 320'd0);
        check("rst_load_ready", 320'(load_ready), 320'd0);
        check("rst_ram_wren", 320'(ram_wren), 320'd0);
        check("rst_ram_data", 320'(ram_data), 320'd0);
        check("rst_row_valid", 320'(row_valid), 320'd0);
        step();
        rst_n = 1'b1;
        step();

        // Full load, words k<<11 per element
        for (int k = 0; k < NCOL; k++) exp_mem[k] = mk_word(k, 0);
        push_writes(NCOL, 0, 1'b1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_ready_rise", 320'(load_ready), 320'd1);
        load_valid = 1'b1;
        for (int k = 0; k < NCOL; k++) begin
            load_data = mk_word(k, 0);
            step();
        end
        load_valid = 1'b0;
        check("load_done_pulse", 320'(load_done), 320'd1);
        check("load_last_addr", 320'(ram_addr), 320'd15);
        check("load_ready_drop", 320'(load_ready), 320'd0);
        step();
        check("load_idle_busy", 320'(busy), 320'd0);
        check("load_done_single", 320'(load_done_cnt), 320'd1);
        check("load_writes_left", 320'(wq.size()), 320'd0);

        // Two passes, no backpressure, latency and gap check
        push_rows(2);
        row_ready = 1'b1;
        run_passes = 8'd2;
        run_start = 1'b1;
        base = run_done_cnt;
        step();
        run_start = 1'b0;
        run_passes = 8'd0;
        step();
        check("first_addr", 320'(ram_addr), 320'd0);
        check("lat_e1_valid", 320'(row_valid), 320'd0);
        step();
        check("lat_e2_valid", 320'(row_valid), 320'd0);
        step();
        for (int i = 0; i < 2 * NCOL; i++) begin
            check("no_gap_valid", 320'(row_valid), 320'd1);
            step();
        end
        check("p2_valid_end", 320'(row_valid), 320'd0);
        check("p2_idle", 320'(busy), 320'd0);
        check("p2_run_done", 320'(run_done_cnt - base), 320'd1);
        check("p2_rows_left", 320'(rq.size()), 320'd0);

        // One pass with ready pattern 1,0,0,1
        push_rows(1);
        run_passes = 8'd1;
        run_start = 1'b1;
        base = run_done_cnt;
        step();
        run_start = 1'b0;
        cyc = 0;
        while (run_done_cnt == base && cyc < 300) begin
            row_ready = pat[cyc % 4];
            step();
            cyc++;
        end
        check("bp_run_done", 320'(run_done_cnt - base), 320'd1);
        row_ready = 1'b1;
        step();
        check("bp_rows_left", 320'(rq.size()), 320'd0);
        check("bp_idle", 320'(busy), 320'd0);

        // Simultaneous starts, then run_start during LOAD
        push_writes(NCOL, 0, 1'b1);
        base = run_done_cnt;
        load_start = 1'b1;
        run_start = 1'b1;
        run_passes = 8'd1;
        step();
        load_start = 1'b0;
        run_start = 1'b0;
        check("both_start_load", 320'(load_ready), 320'd1);
        load_valid = 1'b1;
        for (int k = 0; k < NCOL; k++) begin
            load_data = mk_word(k, 0);
            run_start = (k == 5);
            step();
        end
        load_valid = 1'b0;
        run_start = 1'b0;
        check("both_load_done", 320'(load_done), 320'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_read_busy", 320'(busy), 320'd0);
            check("no_read_valid", 320'(row_valid), 320'd0);
            check("no_read_addr", 320'(ram_addr), 320'd15);
        end
        check("no_run_done", 320'(run_done_cnt - base), 320'd0);

        // Reset after the 8th beat of a new load
        push_writes(8, 3, 1'b0);
        base = load_done_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            load_data = mk_word(k, 3);
            step();
        end
        load_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 320'(busy), 320'd0);
        check("abort_load_ready", 320'(load_ready), 320'd0);
        check("abort_ram_addr", 320'(ram_addr), 320'd0);
        check("abort_ram_data", 320'(ram_data), 320'd0);
        check("abort_load_done", 320'(load_done_cnt - base), 320'd0);
        check("abort_writes_left", 320'(wq.size()), 320'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 8; k++) exp_mem[k] = mk_word(k, 3);
        push_rows(1);
        run_passes = 8'd1;
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        wait_run_done(100);
        step();
        check("mixed_rows_left", 320'(rq.size()), 320'd0);

        // run_passes = 0 behaves as one pass
        push_rows(1);
        base = rows_seen;
        run_passes = 8'd0;
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        wait_run_done(100);
        step();
        check("zero_pass_rows", 320'(rows_seen - base), 320'd16);
        check("zero_pass_left", 320'(rq.size()), 320'd0);
        check("zero_pass_idle", 320'(busy), 320'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
